mm_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported main memory between the ARC datapath (requester 0) and the UART loader/DMA engine (requester 1).
- Sits between the requesters and main_memory. It sequences each access as arbitrate, drive memory for MEM_LAT cycles, capture read data, then acknowledge.
- Round-robin fairness; one outstanding access at a time.

---
 rtl/arc_pkg.sv | 27 ++
 rtl/mm_arbiter_rr_pick2.sv | 24 ++
 rtl/mm_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mm_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc_pkg.sv
// Shared definitions for the main-memory arbiter: FSM state encoding,
// requester indices and the owner-to-grant helper.
package arc_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  function automatic logic [1:0] owner_onehot(input logic idx);
    logic [1:0] oh;
    if (idx == REQ_LDR) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mm_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: a lone requester wins,
// and on a tie the requester that did not win last time goes first.
module rr_pick2
  import arc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       valid
);

  // Pick the winner from the current request pair and the previous owner
  always_comb begin
    valid  = |req;
    winner = REQ_CPU;
    case (req)
      2'b01:   winner = REQ_CPU;
      2'b10:   winner = REQ_LDR;
      2'b11:   winner = ~last_owner;
      default: winner = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mm_arbiter.sv
// Two-port main-memory arbiter: grants one requester at a time, holds the
// memory strobe for MEM_LAT cycles, captures read data, then pulses ack.
module mm_arbiter
  import arc_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    gnt,
  output logic          busy
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          last_owner_q, last_owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          r0_ack_q, r0_ack_d;
  logic          r1_ack_q, r1_ack_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;
  logic          busy_q, busy_d;

  logic          pick_winner_s;
  logic          pick_valid_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  rr_pick2 u_pick (
    .req        ({r1_req, r0_req}),
    .last_owner (last_owner_q),
    .winner     (pick_winner_s),
    .valid      (pick_valid_s)
  );

  // Route the winning requester's command onto a single capture path
  always_comb begin
    if (pick_winner_s == REQ_LDR) begin
      sel_we_s    = r1_we;
      sel_addr_s  = r1_addr;
      sel_wdata_s = r1_wdata;
    end else begin
      sel_we_s    = r0_we;
      sel_addr_s  = r0_addr;
      sel_wdata_s = r0_wdata;
    end
  end

  // Next-state logic: arbitrate, hold the strobe for MEM_LAT cycles, acknowledge
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_rdata_d   = r0_rdata_q;
    r1_rdata_d   = r1_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          state_d      = S_ACCESS;
          gnt_d        = owner_onehot(pick_winner_s);
          last_owner_d = pick_winner_s;
          we_d         = sel_we_s;
          mem_addr_d   = sel_addr_s;
          mem_wdata_d  = sel_wdata_s;
          cnt_d        = LAT_LOAD;
          mem_rd_d     = ~sel_we_s;
          mem_wr_d     = sel_we_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          r0_ack_d = gnt_q[0];
          r1_ack_d = gnt_q[1];
          // Read data is sampled on the last strobe cycle, while memory still drives it
          if (!we_q && gnt_q[1]) begin
            r1_rdata_d = mem_rdata;
          end else if (!we_q) begin
            r0_rdata_d = mem_rdata;
          end else begin
            r0_rdata_d = r0_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = 2'b00;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops strobes and grant immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= 2'b00;
      we_q         <= 1'b0;
      last_owner_q <= REQ_LDR;
      cnt_q        <= 4'd0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mm_arbiter.sv
// Self-checking bench for mm_arbiter: directed latency/fairness/reset
// sequences plus a randomized run against a transaction-level memory model.
module tb_mm_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LAT    = 3;
  localparam int PERIOD = LAT + 2;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  logic r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;

  logic r0_ack, r1_ack, mem_rd, mem_wr, busy;
  logic [DW-1:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0] gnt;

  logic d1_r0_ack, d1_r1_ack, d1_mem_rd, d1_mem_wr, d1_busy;
  logic [DW-1:0] d1_r0_rdata, d1_r1_rdata, d1_mem_wdata, d1_mem_rdata;
  logic [AW-1:0] d1_mem_addr;
  logic [1:0] d1_gnt;

  mm_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt(gnt), .busy(busy)
  );

  // Second instance with single-cycle memory latency, shares the request inputs
  mm_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(d1_r0_ack), .r0_rdata(d1_r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(d1_r1_ack), .r1_rdata(d1_r1_rdata),
    .mem_rd(d1_mem_rd), .mem_wr(d1_mem_wr), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(d1_mem_rdata), .gnt(d1_gnt), .busy(d1_busy)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(i * 7);
  endfunction

  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_wr) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata    = mem_rd ? mem[mem_addr[9:2]] : 32'h0;
  assign d1_mem_rdata = (d1_mem_rd && d1_mem_addr == 32'h40) ? 32'hDEAD_BEEF : 32'h0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    r0_req = 1'b0;
    r1_req = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("idle within budget", busy, 1'b0);
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  typedef struct {
    logic       r1_req_next;
    logic       exp_wr;
    logic       exp_ack1;
    logic [1:0] exp_gnt;
    logic       exp_busy;
  } vec_t;
  vec_t tbl [5];

  logic          act [2];
  logic          we_m [2];
  logic [AW-1:0] ad_m [2];
  logic [DW-1:0] wd_m [2];
  int            wt [2];
  logic [DW-1:0] ref_mem [256];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd3, rd1, a0, acks, c0, c1, cyc, last_cyc;
    logic re0, re1, ak, o;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

    rst = 1'b0; mem_clr = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("reset strobes/gnt/busy", {mem_rd, mem_wr, gnt, busy}, 5'b0);
    check("reset addr/wdata", {mem_addr, mem_wdata}, 64'h0);
    check("reset acks", {r0_ack, r1_ack}, 2'b00);
    check("reset rdata", {r0_rdata, r1_rdata}, 64'h0);
    check("reset d1", {d1_mem_wr, d1_gnt, d1_busy, d1_mem_wdata, d1_r1_rdata}, 68'h0);
    @(negedge clk);
    mem_clr = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Single read from requester 0 on both latencies
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    rd3 = 0; rd1 = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rd3 += int'(mem_rd);
      rd1 += int'(d1_mem_rd);
      if (k == 1) check("t1 addr", {d1_mem_addr, mem_addr}, {32'h40, 32'h40});
      if (k == 2) begin
        check("t1 d1 ack", {d1_r0_ack, d1_r1_ack}, 2'b10);
        check("t1 d1 rdata", d1_r0_rdata, 32'hDEAD_BEEF);
        r0_req = 1'b0;
      end
      check("t1 r0_ack timing", r0_ack, (k == 4));
      check("t1 r1_ack low", r1_ack, 1'b0);
      if (k == 4) check("t1 rdata", r0_rdata, 32'hDEAD_BEEF);
    end
    check("t1 mem_rd cycles lat3", rd3, 3);
    check("t1 mem_rd cycles lat1", rd1, 1);
    wait_idle(20);

    // Write from requester 1, table-driven per-cycle expectations
    drive(1, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2 mem_wr", mem_wr, tbl[k].exp_wr);
      check("t2 mem_rd", mem_rd, 1'b0);
      check("t2 r1_ack", r1_ack, tbl[k].exp_ack1);
      check("t2 r0_ack", r0_ack, 1'b0);
      check("t2 gnt", gnt, tbl[k].exp_gnt);
      check("t2 busy", busy, tbl[k].exp_busy);
      if (tbl[k].exp_wr) check("t2 addr/data", {mem_addr, mem_wdata}, {32'h100, 32'h1234_5678});
      if (tbl[k].exp_ack1) check("t2 r1_rdata unchanged", r1_rdata, 32'h0);
      r1_req = tbl[k].r1_req_next;
    end
    wait_idle(20);

    // Requester 0 drops req one cycle into its access; pending r1 is served next
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    a0 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      a0 += int'(r0_ack);
      if (k == 1) begin
        r0_req = 1'b0;
        drive(1, 1'b1, 1'b0, 32'h100, 32'h0);
      end
      if (k == 4) check("t4 r0_rdata", r0_rdata, 32'hDEAD_BEEF);
      if (k == 6) check("t4 gnt to r1", gnt, 2'b10);
      check("t4 r1_ack timing", r1_ack, (k == 9));
      if (k == 9) begin
        check("t4 r1_rdata", r1_rdata, 32'h1234_5678);
        r1_req = 1'b0;
      end
    end
    check("t4 r0_ack once", a0, 1);
    wait_idle(20);

    // Asynchronous reset in the middle of a write
    drive(0, 1'b1, 1'b1, 32'h80, 32'hCAFE_F00D);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5 mem_wr before reset", mem_wr, 1'b1);
    end
    #2 rst = 1'b0;
    #1;
    check("t5 async drop", {mem_wr, busy, gnt}, 4'b0);
    check("t5 no ack", {r0_ack, r1_ack}, 2'b00);
    drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    check("t5 no ack in reset", {r0_ack, r1_ack, busy}, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    check("t5 first grant r0", gnt, 2'b01);
    wait_idle(20);

    // Fairness: both requesters keep asking after a fresh reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h100, 32'h0);
    acks = 0; c0 = 0; c1 = 0; cyc = 0; last_cyc = -1; re0 = 1'b0; re1 = 1'b0;
    while (acks < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (re0) begin r0_req = 1'b1; re0 = 1'b0; end
      if (re1) begin r1_req = 1'b1; re1 = 1'b0; end
      if (busy) check("t3 gnt onehot", $onehot(gnt), 1'b1);
      if (r0_ack || r1_ack) begin
        check("t3 single ack", r0_ack & r1_ack, 1'b0);
        check("t3 grant order", r1_ack, acks[0]);
        if (last_cyc >= 0) check("t3 ack spacing", cyc - last_cyc, PERIOD);
        last_cyc = cyc;
        acks++;
        if (r0_ack) begin r0_req = 1'b0; c0++; re0 = (c0 < 4); end
        if (r1_ack) begin r1_req = 1'b0; c1++; re1 = (c1 < 4); end
      end
    end
    check("t3 eight acks", acks, 8);
    wait_idle(20);

    // Randomized traffic against a transaction-level memory model
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; we_m[p] = 1'b0; ad_m[p] = '0; wd_m[p] = '0; wt[p] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check("rnd rd&wr exclusive", mem_rd & mem_wr, 1'b0);
      check("rnd ack exclusive", r0_ack & r1_ack, 1'b0);
      if (mem_rd || mem_wr) begin
        o = gnt[1];
        check("rnd strobe gnt onehot", $onehot(gnt), 1'b1);
        check("rnd strobe owner active", act[o], 1'b1);
        check("rnd strobe cmd", {mem_addr, mem_wr}, {ad_m[o], we_m[o]});
        if (mem_wr) check("rnd wdata", mem_wdata, wd_m[o]);
      end
      for (int p = 0; p < 2; p++) begin
        ak = (p == 0) ? r0_ack : r1_ack;
        if (ak) begin
          check("rnd ack while requesting", act[p], 1'b1);
          if (we_m[p]) begin
            ref_mem[ad_m[p][9:2]] = wd_m[p];
          end else begin
            check("rnd read data", (p == 0) ? r0_rdata : r1_rdata, ref_mem[ad_m[p][9:2]]);
          end
          act[p] = 1'b0;
          drive(p, 1'b0, we_m[p], ad_m[p], wd_m[p]);
        end else if (act[p]) begin
          wt[p]++;
          check("rnd wait bound exceeded", wt[p] > 2 * PERIOD, 1'b0);
        end else if ($urandom_range(3) == 0) begin
          act[p]  = 1'b1;
          we_m[p] = 1'($urandom_range(1));
          ad_m[p] = 32'($urandom_range(15)) << 2;
          wd_m[p] = $urandom;
          wt[p]   = 0;
          drive(p, 1'b1, we_m[p], ad_m[p], wd_m[p]);
        end
      end
    end
    wait_idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
